// File: rtl/pll_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pll_ctrl_pkg
// Shared types and constants for the rPLL reconfiguration sequencer.
//   pll_state_e : sequencer states (PRST, WAIT, SETTLE, LOCKED, FAIL)
//   pll_sel_t   : the three dynamic divider-select codes as one bundle
//   *_DEF       : power-on profile, 27 MHz / 3 * 14 -> 126 MHz system clock
//   cnt_inc / retry_inc : saturating increments for the sequencer counters
// ---------------------------------------------------------------------------
package pll_ctrl_pkg;

    localparam int SEL_W   = 6;
    localparam int CNT_W   = 16;
    localparam int RETRY_W = 2;

    typedef enum logic [2:0] {
        ST_PRST   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } pll_state_e;

    typedef struct packed {
        logic [SEL_W-1:0] idsel;
        logic [SEL_W-1:0] fbdsel;
        logic [SEL_W-1:0] odsel;
    } pll_sel_t;

    localparam logic [SEL_W-1:0] IDSEL_DEF  = 6'b111101;  // /3
    localparam logic [SEL_W-1:0] FBDSEL_DEF = 6'b110010;  // x14
    localparam logic [SEL_W-1:0] ODSEL_DEF  = 6'b111110;  // /4

    localparam pll_sel_t SEL_DEF = '{idsel: IDSEL_DEF, fbdsel: FBDSEL_DEF, odsel: ODSEL_DEF};

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// ---------------------------------------------------------------------------
// pll_lock_sync
// Two-flop synchronizer bringing the raw (asynchronous) PLL LOCK into the
// reference-clock domain. Resets to 0 so lock is never assumed at startup.
//   clk      in  reference clock
//   rst_n    in  asynchronous active-low reset
//   pll_lock in  raw PLL LOCK
//   lock_s   out synchronized lock, 2-cycle latency
// ---------------------------------------------------------------------------
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    output logic lock_s
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            meta   <= pll_lock;
            lock_s <= meta;
        end
    end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reconfig_ctrl
// Sequencer for the fabric rPLL producing the system clock from the 27 MHz
// oscillator. Holds the PLL in reset, applies divider-select profiles, waits
// for a filtered lock, retries on timeout / lock drop-out and reports when
// the generated clock may be used. Runs only on the reference clock.
//
// Ports:
//   clk, rst_n                      reference clock, async active-low reset
//   req                             one-cycle request to apply new selects
//   req_idsel/req_fbdsel/req_odsel  select codes captured on accepted req
//   pll_lock                        raw PLL LOCK (asynchronous)
//   pll_reset                       PLL RESET
//   idsel/fbdsel/odsel              PLL dynamic divider selects
//   busy                            sequence running, req ignored
//   locked                          generated clock valid
//   fail                            all attempts exhausted
//   retry_cnt                       failed attempts in current sequence
//
// Build option: define PLL_LOSS_MONITOR_EN to make a lock drop while LOCKED
// trigger an automatic relock with the current selects. Without it, lock is
// not monitored once LOCKED is reached.
//
// SETTLE_CYCLES must be >= 2: the lock sample that moves WAIT to SETTLE is
// counted as the first of the consecutive samples.
// ---------------------------------------------------------------------------
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [SEL_W-1:0]   req_idsel,
    input  logic [SEL_W-1:0]   req_fbdsel,
    input  logic [SEL_W-1:0]   req_odsel,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic [SEL_W-1:0]   idsel,
    output logic [SEL_W-1:0]   fbdsel,
    output logic [SEL_W-1:0]   odsel,
    output logic               busy,
    output logic               locked,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    pll_state_e         state, state_nx;
    // One counter serves as reset-hold count, lock timer and settle count;
    // it is cleared on every state change that uses it.
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [RETRY_W-1:0] retry_nx, retry_next_val;
    pll_sel_t           sel, sel_nx, req_sel;
    logic               lock_s;
    logic               attempt_failed;

    assign req_sel = '{idsel: req_idsel, fbdsel: req_fbdsel, odsel: req_odsel};
    assign retry_next_val = retry_inc(retry_cnt);

    pll_lock_sync u_lock_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .lock_s   (lock_s)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_PRST;
        else        state <= state_nx;
    end

    // ---------------- next state / datapath ----------------
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        retry_nx       = retry_cnt;
        sel_nx         = sel;
        attempt_failed = 1'b0;

        case (state)
            ST_PRST: begin
                if (cnt == RST_LAST) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc(cnt);
                end
            end

            ST_WAIT: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    state_nx = ST_SETTLE;
                    cnt_nx   = '0;
                end else if (cnt == TMO_LAST) begin
                    attempt_failed = 1'b1;
                end else begin
                    cnt_nx = cnt_inc(cnt);
                end
            end

            ST_SETTLE: begin
                if (!lock_s) begin
                    attempt_failed = 1'b1;
                end else if (cnt == SETTLE_LAST) begin
                    state_nx = ST_LOCKED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc(cnt);
                end
            end

            ST_LOCKED: begin
                if (req) begin
                    sel_nx   = req_sel;
                    retry_nx = '0;
                    state_nx = ST_PRST;
                    cnt_nx   = '0;
                end
`ifdef PLL_LOSS_MONITOR_EN
                else if (!lock_s) begin
                    // Relock with the profile already applied.
                    retry_nx = '0;
                    state_nx = ST_PRST;
                    cnt_nx   = '0;
                end
`endif
            end

            ST_FAIL: begin
                if (req) begin
                    sel_nx   = req_sel;
                    retry_nx = '0;
                    state_nx = ST_PRST;
                    cnt_nx   = '0;
                end
            end

            default: begin
                state_nx = ST_PRST;
                cnt_nx   = '0;
            end
        endcase

        // Timeout in WAIT and drop-out in SETTLE share one retry policy.
        if (attempt_failed) begin
            retry_nx = retry_next_val;
            cnt_nx   = '0;
            state_nx = (retry_next_val == RETRY_MAX) ? ST_FAIL : ST_PRST;
        end
    end

    // ---------------- registered datapath and outputs ----------------
    // Outputs are decoded from the next state so they change together with
    // the state and come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            retry_cnt <= '0;
            sel       <= SEL_DEF;
            pll_reset <= 1'b1;
            busy      <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            retry_cnt <= retry_nx;
            sel       <= sel_nx;
            pll_reset <= (state_nx == ST_PRST) || (state_nx == ST_FAIL);
            busy      <= !((state_nx == ST_LOCKED) || (state_nx == ST_FAIL));
            locked    <= (state_nx == ST_LOCKED);
            fail      <= (state_nx == ST_FAIL);
        end
    end

    assign idsel  = sel.idsel;
    assign fbdsel = sel.fbdsel;
    assign odsel  = sel.odsel;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reconfig_ctrl
// Directed sequence with randomized lock delays, glitch positions and select
// codes. Expected event cycles are derived from the timing rules:
//   input driven after edge k is first seen by the sequencer at edge k+3,
//   reset hold = RST cycles, timeout = LT cycles in WAIT,
//   locked follows the first high lock sample in WAIT by SC-1 edges.
// Short LOCK_TIMEOUT / SETTLE_CYCLES keep the run brief.
// ---------------------------------------------------------------------------
module tb_pll_reconfig_ctrl;

    localparam int RST = 16;
    localparam int LT  = 200;
    localparam int SC  = 40;
    localparam int MR  = 3;

    localparam int S_RST    = 0;
    localparam int S_LOCKED = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       pll_lock = 1'b0;
    logic [5:0] req_idsel = '0, req_fbdsel = '0, req_odsel = '0;
    logic       pll_reset, busy, locked, fail;
    logic [5:0] idsel, fbdsel, odsel;
    logic [1:0] retry_cnt;

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [17:0] exp_sel;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pll_reconfig_ctrl #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SC),
        .MAX_RETRY     (MR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_idsel  (req_idsel),
        .req_fbdsel (req_fbdsel),
        .req_odsel  (req_odsel),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .idsel      (idsel),
        .fbdsel     (fbdsel),
        .odsel      (odsel),
        .busy       (busy),
        .locked     (locked),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_sel(input string tag);
        chk(tag, {14'd0, idsel, fbdsel, odsel}, {14'd0, exp_sel});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig(input int which);
        return (which == S_RST) ? pll_reset : locked;
    endfunction

    // Advance until the chosen output has the value; 'at' is the edge after
    // which it was first seen. An expired bound shows up as a failed check.
    task automatic wait_sig(input string tag, input int which, input logic val,
                            input int bound, output int at);
        int n = 0;
        while (sig(which) !== val && n < bound) begin
            tick(1);
            n++;
        end
        at = cyc;
        chk({tag, "_reached"}, {31'd0, sig(which)}, {31'd0, val});
    endtask

    task automatic issue_req(input logic [17:0] s);
        {req_idsel, req_fbdsel, req_odsel} = s;
        req = 1'b1;
        tick(1);
        req = 1'b0;
    endtask

    function automatic logic [17:0] rnd_diff(input logic [17:0] base);
        logic [17:0] m;
        m = 18'($urandom_range(1, 262143));
        return base ^ m;
    endfunction

    initial begin
        int r, k, w, w2, e1, at, g, p, q;
        logic [17:0] nsel, junk;

        exp_sel = {6'b111101, 6'b110010, 6'b111110};

        // ---------------- reset state ----------------
        tick(3);
        chk("rst_pll_reset", {31'd0, pll_reset}, 1);
        chk("rst_busy",      {31'd0, busy},      1);
        chk("rst_locked",    {31'd0, locked},    0);
        chk("rst_fail",      {31'd0, fail},      0);
        chk("rst_retry",     {30'd0, retry_cnt}, 0);
        chk_sel("rst_sel");

        // ---------------- first lock after reset ----------------
        rst_n = 1'b1;
        r = cyc;
        k = r + $urandom_range(5, 150);
        if (k <= r + RST) begin
            tick(k - r);
            pll_lock = 1'b1;
            wait_sig("t1_prst", S_RST, 1'b0, RST + 5, at);
        end else begin
            wait_sig("t1_prst", S_RST, 1'b0, RST + 5, at);
            tick(k - cyc);
            pll_lock = 1'b1;
        end
        chk("t1_reset_fall", at, r + RST);
        e1 = (k + 3 > r + RST + 1) ? k + 3 : r + RST + 1;
        wait_sig("t1_lock", S_LOCKED, 1'b1, 400, at);
        chk("t1_locked_cycle", at, e1 + SC - 1);
        chk("t1_busy",   {31'd0, busy},      0);
        chk("t1_retry",  {30'd0, retry_cnt}, 0);
        chk("t1_pllrst", {31'd0, pll_reset}, 0);
        chk_sel("t1_sel");

        // ---------------- req in LOCKED, reqs while busy ignored ----------------
        tick($urandom_range(1, 10));
        nsel = rnd_diff(exp_sel);
        q = cyc;
        issue_req(nsel);
        exp_sel = nsel;
        chk_sel("t3_sel_update");
        chk("t3_pllrst", {31'd0, pll_reset}, 1);
        chk("t3_busy",   {31'd0, busy},      1);
        chk("t3_locked", {31'd0, locked},    0);
        tick(3);
        junk = rnd_diff(exp_sel);
        issue_req(junk);
        chk_sel("t3_req_in_prst_ignored");
        wait_sig("t3_prst", S_RST, 1'b0, RST + 5, w);
        chk("t3_reset_fall", w, q + 1 + RST);
        tick(5);
        junk = rnd_diff(exp_sel);
        issue_req(junk);
        chk_sel("t3_req_in_settle_ignored");
        chk("t3_busy_settle", {31'd0, busy}, 1);
        wait_sig("t3_lock", S_LOCKED, 1'b1, 400, at);
        chk("t3_locked_cycle", at, w + SC);

        // ---------------- one-cycle glitch during SETTLE ----------------
        tick($urandom_range(1, 10));
        nsel = rnd_diff(exp_sel);
        q = cyc;
        issue_req(nsel);
        exp_sel = nsel;
        wait_sig("t4_prst", S_RST, 1'b0, RST + 5, w);
        chk("t4_reset_fall", w, q + 1 + RST);
        g = w + 1 + $urandom_range(1, SC - 5);
        tick(g - cyc);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        wait_sig("t4_retry_prst", S_RST, 1'b1, 10, at);
        chk("t4_prst_cycle", at, g + 3);
        chk("t4_retry",  {30'd0, retry_cnt}, 1);
        chk("t4_busy",   {31'd0, busy},      1);
        wait_sig("t4_prst2", S_RST, 1'b0, RST + 5, w2);
        chk("t4_reset_fall2", w2, g + 3 + RST);
        wait_sig("t4_lock", S_LOCKED, 1'b1, 400, at);
        chk("t4_locked_cycle", at, w2 + SC);
        chk("t4_retry_held", {30'd0, retry_cnt}, 1);
        chk_sel("t4_sel");

        // ---------------- lock loss while LOCKED ----------------
        tick($urandom_range(2, 10));
        k = cyc;
        pll_lock = 1'b0;
`ifdef PLL_LOSS_MONITOR_EN
        wait_sig("t5_loss", S_LOCKED, 1'b0, 10, at);
        chk("t5_unlock_cycle", at, k + 3);
        chk("t5_busy",   {31'd0, busy},      1);
        chk("t5_pllrst", {31'd0, pll_reset}, 1);
        chk("t5_retry",  {30'd0, retry_cnt}, 0);
        chk_sel("t5_sel_kept");
        p = at;
`else
        tick(10);
        chk("t5_locked_kept", {31'd0, locked},    1);
        chk("t5_busy",        {31'd0, busy},      0);
        chk("t5_retry_held",  {30'd0, retry_cnt}, 1);
        nsel = rnd_diff(exp_sel);
        q = cyc;
        issue_req(nsel);
        exp_sel = nsel;
        chk_sel("t5_sel_update");
        chk("t5_retry_clr", {30'd0, retry_cnt}, 0);
        chk("t5_pllrst",    {31'd0, pll_reset}, 1);
        p = q + 1;
`endif

        // ---------------- three timeouts -> FAIL ----------------
        for (int a = 1; a <= MR; a++) begin
            wait_sig("t6_prst", S_RST, 1'b0, RST + 5, at);
            chk("t6_reset_fall", at, p + a * RST + (a - 1) * LT);
            if (a == 2) begin
                tick(7);
                junk = rnd_diff(exp_sel);
                issue_req(junk);
                chk_sel("t6_req_in_wait_ignored");
                chk("t6_busy_wait", {31'd0, busy}, 1);
            end
            wait_sig("t6_timeout", S_RST, 1'b1, LT + 5, at);
            chk("t6_timeout_cycle", at, p + a * (RST + LT));
            chk("t6_retry", {30'd0, retry_cnt}, a);
            chk("t6_fail",  {31'd0, fail}, (a == MR) ? 1 : 0);
        end
        tick(20);
        chk("t6_fail_hold", {31'd0, fail},      1);
        chk("t6_busy",      {31'd0, busy},      0);
        chk("t6_locked",    {31'd0, locked},    0);
        chk("t6_pllrst",    {31'd0, pll_reset}, 1);
        chk("t6_retry_max", {30'd0, retry_cnt}, MR);

        // ---------------- req in FAIL restarts ----------------
        nsel = rnd_diff(exp_sel);
        pll_lock = 1'b1;
        q = cyc;
        issue_req(nsel);
        exp_sel = nsel;
        chk("t7_fail_clr",  {31'd0, fail},      0);
        chk("t7_retry_clr", {30'd0, retry_cnt}, 0);
        chk("t7_busy",      {31'd0, busy},      1);
        chk_sel("t7_sel_update");
        wait_sig("t7_prst", S_RST, 1'b0, RST + 5, w);
        chk("t7_reset_fall", w, q + 1 + RST);
        wait_sig("t7_lock", S_LOCKED, 1'b1, 400, at);
        chk("t7_locked_cycle", at, w + SC);
        chk("t7_busy_done", {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
